// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI mode-0 slave receiver with byte handshake, status/echo MISO and overrun/abort flags
module spi_slave_rx #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  spi_sclk,
   input  logic                  spi_cs_n,
   input  logic                  spi_mosi,
   output logic                  spi_miso,
   output logic                  spi_miso_oe,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  overrun,
   input  logic                  clr_overrun,
   output logic                  frame_abort
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic {
      ST_IDLE,
      ST_ACTIVE
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, cs_prev_q, mosi_bit_q;
   logic                   sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q;
   logic                   started_q, cs_seen_high_q;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-2:0]  rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
   logic                   miso_q, miso_d;
   logic                   miso_oe_q, miso_oe_d;
   logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   overrun_q, overrun_d;
   logic                   abort_q, abort_d;

   logic [DATA_WIDTH-1:0]  assembled;
   logic [DATA_WIDTH-1:0]  status;
   logic                   byte_done;
   logic                   ovr_evt;

   // A CS that is already low when reset releases must not open a frame,
   // so falls only count once the pin itself has been sampled high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q    <= '0;
         cs_sync_q      <= '1;
         mosi_sync_q    <= '0;
         sclk_prev_q    <= 1'b0;
         cs_prev_q      <= 1'b1;
         mosi_bit_q     <= 1'b0;
         sclk_rise_q    <= 1'b0;
         sclk_fall_q    <= 1'b0;
         cs_fall_q      <= 1'b0;
         cs_rise_q      <= 1'b0;
         started_q      <= 1'b0;
         cs_seen_high_q <= 1'b0;
      end else begin
         sclk_sync_q    <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync_q    <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         sclk_prev_q    <= sclk_sync_q[SYNC_STAGES-1];
         cs_prev_q      <= cs_sync_q[SYNC_STAGES-1];
         mosi_bit_q     <= mosi_sync_q[SYNC_STAGES-1];
         sclk_rise_q    <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
         sclk_fall_q    <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
         cs_fall_q      <= ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q & cs_seen_high_q;
         cs_rise_q      <= cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
         started_q      <= 1'b1;
         cs_seen_high_q <= cs_seen_high_q | (started_q & cs_sync_q[0]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         miso_q     <= 1'b0;
         miso_oe_q  <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         miso_q     <= miso_d;
         miso_oe_q  <= miso_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         abort_q    <= abort_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      miso_d     = miso_q;
      miso_oe_d  = miso_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = overrun_q;
      abort_d    = 1'b0;
      byte_done  = 1'b0;
      ovr_evt    = 1'b0;
      assembled  = {rx_shift_q, mosi_bit_q};
      status     = '0;
      status[DATA_WIDTH-1] = overrun_q;
      status[DATA_WIDTH-2] = rx_valid_q;

      if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (cs_fall_q) begin
               state_d    = ST_ACTIVE;
               bit_cnt_d  = '0;
               miso_oe_d  = 1'b1;
               tx_shift_d = status;
               miso_d     = status[DATA_WIDTH-1];
            end
         end
         ST_ACTIVE: begin
            if (cs_rise_q) begin
               state_d   = ST_IDLE;
               miso_oe_d = 1'b0;
               miso_d    = 1'b0;
               abort_d   = (bit_cnt_q != '0);
               bit_cnt_d = '0;
            end else if (sclk_rise_q) begin
               rx_shift_d = assembled[DATA_WIDTH-2:0];
               if (bit_cnt_q == LAST_BIT) begin
                  byte_done  = 1'b1;
                  bit_cnt_d  = '0;
                  tx_shift_d = assembled;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (sclk_fall_q) begin
               // The fall right after a completed byte presents the echo MSB unshifted.
               if (bit_cnt_q == '0) begin
                  miso_d = tx_shift_q[DATA_WIDTH-1];
               end else begin
                  tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                  miso_d     = tx_shift_q[DATA_WIDTH-2];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (byte_done) begin
         if (!rx_valid_q || rx_ready) begin
            rx_data_d  = assembled;
            rx_valid_d = 1'b1;
         end else begin
            ovr_evt = 1'b1;
         end
      end

      if (ovr_evt) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = miso_oe_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign overrun     = overrun_q;
   assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - randomized SPI frames checked each cycle against a byte-level reference model
module tb_spi_slave_rx;

   localparam int DW   = 8;
   localparam int SS   = 2;
   localparam int LAT  = SS + 2;
   localparam int HALF = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          spi_sclk = 1'b0;
   logic          spi_cs_n = 1'b1;
   logic          spi_mosi = 1'b0;
   logic          rx_ready = 1'b0;
   logic          clr_overrun = 1'b0;
   logic          spi_miso, spi_miso_oe, rx_valid, overrun, frame_abort;
   logic [DW-1:0] rx_data;

   spi_slave_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .overrun(overrun), .clr_overrun(clr_overrun), .frame_abort(frame_abort)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   logic rdy_e = 1'b0, clr_e = 1'b0;

   // Model state: what the byte interface must show after each clock edge.
   logic          m_active = 0, m_valid = 0, m_ovr = 0, m_abort = 0;
   logic [DW-1:0] m_data = 0, m_status = 0;
   logic [DW-1:0] ev_comp[int];
   bit            ev_csf[int];
   bit            ev_csr[int];

   logic [DW-1:0] acc_q[$];
   int            abort_cnt = 0;
   int            rv_rise_cyc = 0;
   int            last_rise_cyc = 0;
   logic          rv_prev = 1'b0;
   logic [DW-1:0] fr_data[4];
   logic [DW-1:0] obs[4];
   int            pulse_cyc = -100;
   bit            rand_hs = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rdy_e <= rx_ready;
      clr_e <= clr_overrun;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         m_active = 0; m_valid = 0; m_ovr = 0; m_abort = 0; m_data = 0; m_status = 0;
         check("rst_miso", spi_miso, 0);
         check("rst_oe", spi_miso_oe, 0);
         check("rst_data", rx_data, 0);
         check("rst_valid", rx_valid, 0);
         check("rst_overrun", overrun, 0);
         check("rst_abort", frame_abort, 0);
      end else begin
         logic ovr_evt;
         ovr_evt = 0;
         m_abort = 0;
         if (ev_csf.exists(cyc)) begin
            m_status = {m_ovr, m_valid, 6'b0};
            m_active = 1;
            ev_csf.delete(cyc);
         end
         if (ev_comp.exists(cyc)) begin
            if (!m_valid || rdy_e) begin
               m_data  = ev_comp[cyc];
               m_valid = 1;
            end else begin
               ovr_evt = 1;
            end
            ev_comp.delete(cyc);
         end else if (m_valid && rdy_e) begin
            m_valid = 0;
         end
         if (ovr_evt) m_ovr = 1;
         else if (clr_e) m_ovr = 0;
         if (ev_csr.exists(cyc)) begin
            m_active = 0;
            m_abort  = ev_csr[cyc];
            ev_csr.delete(cyc);
         end
         check("rx_valid", rx_valid, m_valid);
         check("rx_data", rx_data, m_data);
         check("overrun", overrun, m_ovr);
         check("frame_abort", frame_abort, m_abort);
         check("miso_oe", spi_miso_oe, m_active);
      end
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (rx_valid && !rv_prev) rv_rise_cyc = cyc;
      rv_prev = rx_valid;
      if (frame_abort) abort_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (cyc == pulse_cyc) rx_ready = 1'b1;
      else if (cyc == pulse_cyc + 1) rx_ready = 1'b0;
      if (rand_hs) begin
         rx_ready    = ($urandom_range(0, 1) == 1);
         clr_overrun = ($urandom_range(0, 15) == 0);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   // Sends nb full bytes from fr_data then `partial` bits of the next entry.
   task automatic send_frame(input int nb, input int partial, input bit collide);
      int   total, j, b;
      logic expb;
      spi_cs_n = 1'b0;
      ev_csf[cyc + LAT] = 1;
      total = nb * 8 + partial;
      for (int k = 0; k < total; k++) begin
         j = k / 8;
         b = 7 - (k % 8);
         spi_mosi = fr_data[j][b];
         ticks(HALF);
         expb = (j == 0) ? m_status[b] : fr_data[j-1][b];
         check("miso_bit", spi_miso, expb);
         obs[j][b] = spi_miso;
         spi_sclk = 1'b1;
         if (b == 0) begin
            ev_comp[cyc + LAT] = fr_data[j];
            last_rise_cyc = cyc;
            if (collide && j == nb - 1) pulse_cyc = cyc + LAT - 1;
         end
         ticks(HALF);
         spi_sclk = 1'b0;
      end
      ticks(HALF);
      spi_cs_n = 1'b1;
      ev_csr[cyc + LAT] = (partial != 0);
      ticks(2 * HALF);
   endtask

   initial begin
      int ab0, n0;
      // Reset with random pins, then release with CS high
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         spi_sclk = 1'($urandom); spi_cs_n = 1'($urandom); spi_mosi = 1'($urandom);
         tick();
      end
      spi_sclk = 0; spi_cs_n = 1; spi_mosi = 0;
      ticks(2);
      rst_n = 1'b1;
      ticks(10);
      check("post_rst_valid", rx_valid, 0);
      check("post_rst_oe", spi_miso_oe, 0);

      // Reset released while CS already low: no frame may start
      rst_n = 1'b0; spi_cs_n = 1'b0;
      ticks(3);
      rst_n = 1'b1;
      ticks(12);
      check("cs_low_release_oe", spi_miso_oe, 0);
      spi_cs_n = 1'b1;
      ticks(12);
      check("cs_low_release_abort", abort_cnt, 0);

      // Single byte 0xA5
      rx_ready = 1'b1;
      fr_data[0] = 8'hA5;
      send_frame(1, 0, 0);
      check("single_count", acc_q.size(), 1);
      check("single_byte", acc_q[0], 8'hA5);
      check("single_latency", rv_rise_cyc - last_rise_cyc, LAT);
      check("single_status", obs[0], 8'h00);
      check("single_no_abort", abort_cnt, 0);

      // Back-to-back with echo
      fr_data[0] = 8'h3C; fr_data[1] = 8'hC3;
      send_frame(2, 0, 0);
      check("b2b_first", acc_q[1], 8'h3C);
      check("b2b_second", acc_q[2], 8'hC3);
      check("b2b_echo", obs[1], 8'h3C);

      // Overrun
      rx_ready = 1'b0;
      fr_data[0] = 8'h11; fr_data[1] = 8'h22;
      send_frame(2, 0, 0);
      check("ovr_data", rx_data, 8'h11);
      check("ovr_valid", rx_valid, 1);
      check("ovr_flag", overrun, 1);
      fr_data[0] = 8'h00;
      send_frame(1, 0, 0);
      check("ovr_status_obs", obs[0], 8'hC0);
      check("ovr_status_model", m_status, 8'hC0);
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      ticks(2);
      check("ovr_cleared", overrun, 0);
      rx_ready = 1'b1;
      ticks(3);
      check("ovr_drain", acc_q[acc_q.size()-1], 8'h11);
      check("ovr_drain_valid", rx_valid, 0);

      // Abort after 5 bits
      ab0 = abort_cnt; n0 = acc_q.size();
      fr_data[0] = 8'hFF;
      send_frame(0, 5, 0);
      check("abort_pulse", abort_cnt, ab0 + 1);
      check("abort_no_byte", acc_q.size(), n0);
      fr_data[0] = 8'h5A;
      send_frame(1, 0, 0);
      check("after_abort_byte", acc_q[acc_q.size()-1], 8'h5A);

      // Completion coinciding with an accepting handshake
      rx_ready = 1'b0;
      fr_data[0] = 8'h01;
      send_frame(1, 0, 0);
      check("coll_pre_valid", rx_valid, 1);
      check("coll_pre_data", rx_data, 8'h01);
      fr_data[0] = 8'h02;
      send_frame(1, 0, 1);
      pulse_cyc = -100;
      check("coll_data", rx_data, 8'h02);
      check("coll_valid", rx_valid, 1);
      check("coll_overrun", overrun, 0);
      check("coll_accepted", acc_q[acc_q.size()-1], 8'h01);
      rx_ready = 1'b1;
      ticks(4);

      // Randomized frames with random handshake and overrun clears
      rand_hs = 1;
      for (int f = 0; f < 30; f++) begin
         int nb, part;
         nb   = $urandom_range(1, 3);
         part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         for (int i = 0; i < 4; i++) fr_data[i] = 8'($urandom);
         send_frame(nb, part, 0);
      end
      rand_hs = 0;
      rx_ready = 1'b1;
      clr_overrun = 1'b0;
      ticks(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI mode-0 slave front end that deserializes MOSI bytes in the clk domain and presents them on a valid/ready byte interface to the SPI-to-I2C FIFO bridge. rx_valid/rx_data feed the bridge's spi_start/spi_data. rx_ready is driven by the bridge's accept condition (bridge IDLE and FIFO not full). The block also returns a status byte and then a byte echo on MISO, and flags overrun and aborted frames.

Parameters:
DATA_WIDTH, 8, bits per SPI word and width of rx_data
SYNC_STAGES, 2, flip-flop synchronizer depth on spi_sclk, spi_cs_n and spi_mosi (minimum 2)

Ports:
clk  input  1  system clock; must be at least 8x spi_sclk
rst_n  input  1  asynchronous active-low reset
spi_sclk  input  1  SPI clock, asynchronous, idle low
spi_cs_n  input  1  SPI chip select, active low, asynchronous
spi_mosi  input  1  SPI data in, MSB first
spi_miso  output  1  SPI data out, MSB first
spi_miso_oe  output  1  MISO output enable; high while the frame is active
rx_data  output  DATA_WIDTH  received byte in the holding register
rx_valid  output  1  holding register full
rx_ready  input  1  downstream accepts when rx_valid && rx_ready
overrun  output  1  sticky: a completed byte was dropped because the holding register was full
clr_overrun  input  1  one-cycle pulse; clears overrun
frame_abort  output  1  one-cycle pulse; CS deasserted with a partial byte in progress

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, overrun=0, frame_abort=0. Also cleared by reset: bit counter, shift registers, synchronizers (sclk/mosi sync to 0, cs_n sync to 1).
- Synchronization and edge detection:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last sync stage with one further registered copy.
  - sclk_rise, sclk_fall, cs_fall and cs_rise are each one-cycle strobes.
- Frame states: IDLE (cs_n high) and ACTIVE (cs_n low).
  - cs_fall: go to ACTIVE; bit_cnt=0; spi_miso_oe=1; tx_shift loaded with the status byte {overrun, rx_valid, 0...}; spi_miso = status MSB in the same cycle.
  - cs_rise: go to IDLE; spi_miso_oe=0. If bit_cnt != 0, discard the partial byte and pulse frame_abort for one cycle. bit_cnt returns to 0.
  - SCLK edges seen in IDLE are ignored.
- Receive (ACTIVE only):
  - On sclk_rise, shift the synchronized MOSI into the LSB of rx_shift and increment bit_cnt (width clog2(DATA_WIDTH)+1).
  - When bit_cnt reaches DATA_WIDTH-1 before the increment, the byte is complete: the assembled word {rx_shift[DATA_WIDTH-2:0], mosi} is the completed byte, and bit_cnt wraps to 0.
- Transmit:
  - On sclk_fall in ACTIVE, shift tx_shift left by one; spi_miso = new MSB.
  - On byte completion, tx_shift loads the completed byte. The echo appears on MISO starting with the first bit of the next byte.
- Holding register / handshake:
  - On byte completion with rx_valid=0: rx_data = byte and rx_valid=1 in the next cycle. Latency is 1 clk after the sclk_rise strobe, which is SYNC_STAGES+2 clk after the pin edge.
  - rx_valid && rx_ready: rx_valid clears the next cycle; rx_data holds its value.
  - Byte completion in the same cycle as an accepting handshake: the new byte loads, rx_valid stays 1, no overrun.
  - Byte completion with rx_valid=1 and no handshake that cycle: the byte is dropped, rx_data is unchanged, overrun=1 (sticky).
  - overrun clears only on clr_overrun. If clr_overrun coincides with a new overrun event, overrun stays 1.
- rx_data/rx_valid persist across frame boundaries; a CS edge does not clear them.
- Reset asserted mid-frame: all state is returned to reset values immediately. After release, the block waits for a fresh cs_fall; the current low CS is not treated as a frame start.

Test Plan:
1. Reset check: hold rst_n low with random SPI pins -> all outputs are at reset values. Release with cs_n=1 -> rx_valid=0, spi_miso_oe=0.
2. Single byte, rx_ready=1: cs_n low, shift 0xA5, cs_n high.
   - rx_valid pulses for one cycle with rx_data=0xA5, SYNC_STAGES+2 clk after the 8th rising SCLK.
   - MISO carries status 0x00 for that byte; no frame_abort.
3. Back-to-back in one frame, rx_ready=1: 0x3C then 0xC3 -> two accepted bytes in order, and MISO bits of byte 2 = 0x3C (echo).
4. Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11, rx_valid=1, overrun=1.
   - Next frame's status byte = 0xC0.
   - clr_overrun pulse -> overrun=0; raising rx_ready then accepts 0x11.
5. Abort: cs_n high after 5 SCLKs of 0xFF -> one frame_abort pulse and no rx_valid. Next full byte 0x5A is received correctly (bit_cnt was reset).
6. Handshake collision: rx_valid=1 with 0x01; the 8th edge of 0x02 lands in the same cycle as rx_ready=1 -> rx_data=0x02, rx_valid stays 1, overrun=0.
